// File: rtl/ram_rd_stream.sv
// ram_rd_stream: turns (addr, len) commands into held RAM reads and streams the words out
// through a 2-entry buffer, so downstream backpressure never cuts a RAM read short.
module ram_rd_stream #(
  parameter int AddrWidth = 9
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [AddrWidth-1:0] i_cmd_addr,
  input  logic [AddrWidth:0]   i_cmd_len,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  output logic [AddrWidth-1:0] o_ram_rd_addr,
  output logic                 o_ram_rd_valid,
  input  logic                 i_ram_rd_ready,
  input  logic [31:0]          i_ram_rd_data,
  output logic [31:0]          o_out_data,
  output logic                 o_out_last,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic                 o_busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, DRAIN} state_t;
  state_t               r_state, w_next;
  logic [AddrWidth-1:0] r_addr;
  logic [AddrWidth:0]   r_remaining;
  logic [31:0]          r_data [2];
  logic [1:0]           r_last;
  logic                 r_wr, r_rd;
  logic [1:0]           r_cnt, w_cnt_next;
  logic                 w_accept, w_push, w_pop, w_is_last;
  assign w_accept   = i_cmd_valid & o_cmd_ready & (i_cmd_len != '0);
  assign w_push     = (r_state == HOLD) & i_ram_rd_ready;
  assign w_pop      = o_out_valid & i_out_ready;
  assign w_is_last  = r_remaining == (AddrWidth+1)'(1);
  assign w_cnt_next = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
  always_comb begin
    w_next         = r_state;
    o_ram_rd_valid = 1'b0;
    case (r_state)
      IDLE:  w_next = w_accept ? ISSUE : IDLE;
      ISSUE: begin
        o_ram_rd_valid = r_cnt < 2'd2;
        w_next         = (r_cnt < 2'd2) ? HOLD : ISSUE;
      end
      // rd_valid must stay up until ready, otherwise the RAM drops the read
      HOLD:  begin
        o_ram_rd_valid = 1'b1;
        w_next         = !i_ram_rd_ready ? HOLD : w_is_last ? DRAIN : (w_cnt_next == 2'd2) ? ISSUE : HOLD;
      end
      DRAIN: w_next = (w_cnt_next == 2'd0) ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_data[0]   <= '0;
      r_data[1]   <= '0;
      r_last      <= '0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr      <= i_cmd_addr;
        r_remaining <= i_cmd_len;
      end
      if (w_push) begin
        r_addr         <= r_addr + AddrWidth'(1);
        r_remaining    <= r_remaining - (AddrWidth+1)'(1);
        r_data[r_wr]   <= i_ram_rd_data;
        r_last[r_wr]   <= w_is_last;
        r_wr           <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
    end
  end
  assign o_busy        = r_state != IDLE;
  assign o_cmd_ready   = !o_busy;
  assign o_ram_rd_addr = r_addr;
  assign o_out_valid   = r_cnt != 2'd0;
  assign o_out_data    = r_data[r_rd];
  assign o_out_last    = o_out_valid & r_last[r_rd];
endmodule
